// File: rtl/freq_ratio_monitor.sv
// Measures period and high time of a divided clock in system-clock cycles and
// derives divide ratio, power-of-two exponent, 50% duty flag, lock and loss-of-signal.
module freq_ratio_monitor #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             no_signal,
    output logic             is_pow2,
    output logic [4:0]       div_exp,
    output logic             duty_50
);

    localparam int MW = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
    logic [MW-1:0]    match_q, match_d;
    logic             have_prev_q, have_prev_d;
    logic             meas_valid_q, meas_valid_d, locked_q, locked_d;
    logic             no_signal_q, no_signal_d, is_pow2_q, is_pow2_d, duty_50_q, duty_50_d;
    logic [4:0]       div_exp_q, div_exp_d;
    logic             rise;
    logic [CNT_W-1:0] high_meas;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [4:0] onehot_log2(input logic [CNT_W-1:0] v);
        logic [4:0] e;
        e = '0;
        for (int i = 0; i < CNT_W; i++)
            if (v[i]) e = 5'(i);
        return e;
    endfunction

    always_comb begin
        s1_d         = sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        rise         = s2_q & ~s3_q;
        high_meas    = s3_q ? sat_inc(hcnt_q) : hcnt_q;
        state_d      = state_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        match_d      = match_q;
        have_prev_d  = have_prev_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        no_signal_d  = no_signal_q;
        is_pow2_d    = is_pow2_q;
        div_exp_d    = div_exp_q;
        duty_50_d    = duty_50_q;

        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = '0;
        end else begin
            cnt_d  = sat_inc(cnt_q);
            hcnt_d = high_meas;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d     = ST_MEASURE;
                    no_signal_d = 1'b0;
                    have_prev_d = 1'b0;
                    match_d     = '0;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (rise) begin
                    // A rise coinciding with saturation still counts as a measurement.
                    period_d     = cnt_q;
                    high_time_d  = high_meas;
                    meas_valid_d = 1'b1;
                    is_pow2_d    = $onehot(cnt_q);
                    div_exp_d    = $onehot(cnt_q) ? onehot_log2(cnt_q) : 5'd0;
                    duty_50_d    = ({high_meas, 1'b0} == {1'b0, cnt_q});
                    if (have_prev_q && (cnt_q == period_q))
                        match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
                    else
                        match_d = '0;
                    have_prev_d = 1'b1;
                    locked_d    = (match_d == MATCH_MAX);
                    state_d     = locked_d ? ST_LOCKED : ST_MEASURE;
                end else if (cnt_q == CNT_MAX) begin
                    no_signal_d = 1'b1;
                    locked_d    = 1'b0;
                    match_d     = '0;
                    have_prev_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable clears everything except the synchronizer, which keeps tracking sig_in.
        if (!en) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            hcnt_d       = '0;
            period_d     = '0;
            high_time_d  = '0;
            match_d      = '0;
            have_prev_d  = 1'b0;
            meas_valid_d = 1'b0;
            locked_d     = 1'b0;
            no_signal_d  = 1'b0;
            is_pow2_d    = 1'b0;
            div_exp_d    = '0;
            duty_50_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            match_q      <= '0;
            have_prev_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            no_signal_q  <= 1'b0;
            is_pow2_q    <= 1'b0;
            div_exp_q    <= '0;
            duty_50_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            match_q      <= match_d;
            have_prev_q  <= have_prev_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            no_signal_q  <= no_signal_d;
            is_pow2_q    <= is_pow2_d;
            div_exp_q    <= div_exp_d;
            duty_50_q    <= duty_50_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign no_signal  = no_signal_q;
    assign is_pow2    = is_pow2_q;
    assign div_exp    = div_exp_q;
    assign duty_50    = duty_50_q;

endmodule

// File: tb/tb_freq_ratio_monitor.sv
// Directed bench for freq_ratio_monitor: sig_in is a programmable high/low waveform
// driven cycle by cycle; expected values are hand-derived from the cycle timing.
module tb_freq_ratio_monitor;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;

    logic             clk = 1'b0;
    logic             rst, en, sig_in;
    logic [CNT_W-1:0] period, high_time;
    logic             meas_valid, locked, no_signal, is_pow2, duty_50;
    logic [4:0]       div_exp;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_n = 4, lo_n = 4, nxt_hi = 4, nxt_lo = 4, phase = 0;
    bit stuck = 1'b0;

    freq_ratio_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .no_signal(no_signal), .is_pow2(is_pow2),
        .div_exp(div_exp), .duty_50(duty_50)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of the waveform; new high/low lengths apply at the next period start.
    task automatic cyc();
        if (phase == 0) begin
            hi_n = nxt_hi;
            lo_n = nxt_lo;
        end
        sig_in = !stuck && (phase < hi_n);
        phase  = (phase + 1 >= hi_n + lo_n) ? 0 : phase + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic restart_wave(input int h, input int l);
        hi_n = h; lo_n = l; nxt_hi = h; nxt_lo = l; phase = 0;
    endtask

    task automatic wait_mv(input string tag, input int maxc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (meas_valid !== 1'b1 && n < maxc);
        check({tag, " meas_valid"}, 32'(meas_valid), 1);
    endtask

    task automatic check_meas(input string tag, input int p, input int h, input int pw,
                              input int ex, input int dt, input int lk);
        check({tag, " period"},    32'(period),    p);
        check({tag, " high_time"}, 32'(high_time), h);
        check({tag, " is_pow2"},   32'(is_pow2),   pw);
        check({tag, " div_exp"},   32'(div_exp),   ex);
        check({tag, " duty_50"},   32'(duty_50),   dt);
        check({tag, " locked"},    32'(locked),    lk);
    endtask

    task automatic check_clear(input string tag);
        check_meas(tag, 0, 0, 0, 0, 0, 0);
        check({tag, " meas_valid"}, 32'(meas_valid), 0);
        check({tag, " no_signal"},  32'(no_signal),  0);
    endtask

    initial begin
        int n;
        int mv_seen;
        rst = 1'b0;
        en  = 1'b1;
        sig_in = 1'b0;

        // Reset with sig_in toggling, then flush the synchronizer low
        restart_wave(1, 1);
        repeat (3) begin
            cyc();
            check("reset meas_valid", 32'(meas_valid), 0);
        end
        check_clear("reset");
        stuck = 1'b1;
        repeat (3) cyc();
        stuck = 1'b0;
        restart_wave(4, 4);
        rst = 1'b1;

        // Divide-by-8: first rise arms, second rise (11 cycles in) measures
        wait_mv("d8 m1", 30, n);
        check("d8 first latency", n, 11);
        check_meas("d8 m1", 8, 4, 1, 3, 1, 0);
        cyc();
        check("d8 single pulse", 32'(meas_valid), 0);
        wait_mv("d8 m2", 20, n);
        check("d8 m2 locked", 32'(locked), 0);
        wait_mv("d8 m3", 20, n);
        check("d8 m3 locked", 32'(locked), 0);
        wait_mv("d8 m4", 20, n);
        check_meas("d8 m4", 8, 4, 1, 3, 1, 1);

        // Switch to period 12 (5 high): the in-flight 8 period completes first
        nxt_hi = 5;
        nxt_lo = 7;
        wait_mv("sw tail", 20, n);
        check("sw tail period", 32'(period), 8);
        check("sw tail locked", 32'(locked), 1);
        wait_mv("p12 m1", 20, n);
        check_meas("p12 m1", 12, 5, 0, 0, 0, 0);
        wait_mv("p12 m2", 20, n);
        check("p12 m2 locked", 32'(locked), 0);
        wait_mv("p12 m3", 20, n);
        check("p12 m3 locked", 32'(locked), 0);
        wait_mv("p12 m4", 20, n);
        check_meas("p12 m4", 12, 5, 0, 0, 0, 1);

        // Stuck low: counter saturates 255 cycles after the last measurement
        stuck = 1'b1;
        n = 0;
        mv_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            n++;
            if (meas_valid === 1'b1) mv_seen++;
            if (no_signal === 1'b1) break;
        end
        check("timeout cycles", n, 255);
        check("timeout no_signal", 32'(no_signal), 1);
        check("timeout locked", 32'(locked), 0);
        check("timeout period held", 32'(period), 12);
        check("timeout high held", 32'(high_time), 5);
        check("timeout no meas_valid", mv_seen, 0);

        // Resume: first rise clears no_signal, second one measures
        stuck = 1'b0;
        restart_wave(4, 4);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n++;
            if (no_signal === 1'b0) break;
        end
        check("resume clear cycles", n, 3);
        check("resume clear meas_valid", 32'(meas_valid), 0);
        wait_mv("resume m1", 20, n);
        check("resume m1 latency", n, 8);
        check_meas("resume m1", 8, 4, 1, 3, 1, 0);
        check("resume no_signal", 32'(no_signal), 0);

        // Toggle every clk: period 2
        en = 1'b0;
        cyc();
        check("dis period", 32'(period), 0);
        check("dis is_pow2", 32'(is_pow2), 0);
        stuck = 1'b1;
        repeat (3) cyc();
        stuck = 1'b0;
        en = 1'b1;
        restart_wave(1, 1);
        wait_mv("p2 m1", 20, n);
        check("p2 m1 latency", n, 5);
        check_meas("p2 m1", 2, 1, 1, 1, 1, 0);
        wait_mv("p2 m2", 10, n);
        check("p2 m2 locked", 32'(locked), 0);
        wait_mv("p2 m3", 10, n);
        check("p2 m3 locked", 32'(locked), 0);
        wait_mv("p2 m4", 10, n);
        check_meas("p2 m4", 2, 1, 1, 1, 1, 1);

        // Mid-period reset pulse, then disable for 10 cycles
        rst = 1'b0;
        cyc();
        check_clear("midrst");
        rst = 1'b1;
        en = 1'b0;
        stuck = 1'b1;
        repeat (10) begin
            cyc();
            check("dis10 meas_valid", 32'(meas_valid), 0);
        end
        check_clear("dis10");
        en = 1'b1;
        stuck = 1'b0;
        restart_wave(4, 4);
        wait_mv("reen m1", 30, n);
        check("reen latency", n, 11);
        check_meas("reen m1", 8, 4, 1, 3, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
